op_share_arbiter: RTL and testbench

OP_SHARE_ARBITER -- requirements
Module: op_share_arbiter

---
 rtl/op_share_arbiter.sv | 127 ++++++++++++
 tb/tb_op_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_share_arbiter.sv
// Round-robin arbiter sharing one request/ack upstream resource among num_clients consumers.
// Optional per-client delivered-item counters are enabled by defining OP_SHARE_ARBITER_STATS_EN.
module op_share_arbiter #(
   parameter int data_width  = 32,
   parameter int num_clients = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [num_clients-1:0] cli_req,
   output logic [num_clients-1:0] cli_ack,
   output logic [data_width-1:0]  cli_dout,
   output logic                   res_req,
   input  logic                   res_ack,
   input  logic [data_width-1:0]  res_din,
   output logic [2:0]             grant,
`ifdef OP_SHARE_ARBITER_STATS_EN
   output logic                   busy,
   output logic [32*num_clients-1:0] gnt_count
`else
   output logic                   busy
`endif
);

   localparam int unsigned IW = (num_clients > 1) ? $clog2(num_clients) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DELIVER
   } state_t;

   state_t                  r_state;
   logic [IW-1:0]           r_last;
   logic [IW-1:0]           r_sel;
   logic [2:0]              r_grant;
   logic                    r_res_req;
   logic                    r_busy;
   logic [num_clients-1:0]  r_cli_ack;
   logic [data_width-1:0]   r_dout;

   logic                    w_found;
   logic [IW-1:0]           w_pick;
   int                      w_sum;
   logic [num_clients-1:0]  w_onehot;

   // Round-robin search starting one past the last served client, wrapping at num_clients.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = 0;
      for (int i = 1; i <= num_clients; i++) begin
         w_sum = int'(r_last) + i;
         if (w_sum >= num_clients) w_sum = w_sum - num_clients;
         if (!w_found && cli_req[IW'(w_sum)]) begin
            w_found = 1'b1;
            w_pick  = IW'(w_sum);
         end
      end
   end

   assign w_onehot = num_clients'(1) << r_sel;

   // Arbitration FSM; a grant is committed once taken, regardless of cli_req afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_last    <= IW'(num_clients - 1);
         r_sel     <= '0;
         r_grant   <= '0;
         r_res_req <= 1'b0;
         r_busy    <= 1'b0;
         r_cli_ack <= '0;
         r_dout    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_sel     <= w_pick;
                  r_grant   <= 3'(w_pick);
                  r_res_req <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (res_ack) begin
                  r_res_req <= 1'b0;
                  r_dout    <= res_din;
                  r_cli_ack <= w_onehot;
                  r_last    <= r_sel;
                  r_state   <= S_DELIVER;
               end
            end
            S_DELIVER: begin
               r_cli_ack <= '0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cli_ack  = r_cli_ack;
   assign cli_dout = r_dout;
   assign res_req  = r_res_req;
   assign grant    = r_grant;
   assign busy     = r_busy;

`ifdef OP_SHARE_ARBITER_STATS_EN
   logic [num_clients-1:0][31:0] r_gnt_count;

   // Per-client delivered-item counters, bumped on the same edge that raises cli_ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt_count <= '0;
      end else if (r_state == S_FETCH && res_ack) begin
         r_gnt_count[r_sel] <= r_gnt_count[r_sel] + 32'd1;
      end
   end

   assign gnt_count = r_gnt_count;
`endif

endmodule

// File: tb/tb_op_share_arbiter.sv
// Directed table-driven bench for op_share_arbiter, plus hand sequences for withdraw and reset-in-fetch.
module tb_op_share_arbiter;

   localparam int DW = 32;
   localparam int NC = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [NC-1:0]  cli_req;
   logic [NC-1:0]  cli_ack;
   logic [DW-1:0]  cli_dout;
   logic           res_req;
   logic           res_ack;
   logic [DW-1:0]  res_din;
   logic [2:0]     grant;
   logic           busy;
`ifdef OP_SHARE_ARBITER_STATS_EN
   logic [32*NC-1:0] gnt_count;
`endif

   op_share_arbiter #(.data_width(DW), .num_clients(NC)) dut (
      .clk      (clk),
      .rst      (rst),
      .cli_req  (cli_req),
      .cli_ack  (cli_ack),
      .cli_dout (cli_dout),
      .res_req  (res_req),
      .res_ack  (res_ack),
      .res_din  (res_din),
      .grant    (grant),
`ifdef OP_SHARE_ARBITER_STATS_EN
      .gnt_count(gnt_count),
`endif
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int last_ack_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // At most one ack bit may be high in any cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         n_tests++;
         if ($countones(cli_ack) > 1) begin
            n_fail++;
            $display("FAIL ack_onehot: got %b expected at most one bit", cli_ack);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst = 1'b1;
      cli_req = '0;
      res_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_item(input logic [NC-1:0] req, input logic [NC-1:0] req_fetch,
                           input int delay, input logic [DW-1:0] data,
                           output logic to, output logic [2:0] g, output logic hold_ok,
                           output logic [NC-1:0] ack, output logic [DW-1:0] dout, output int gap,
                           output logic [NC-1:0] ack2, output logic [DW-1:0] dout2,
                           output logic busy2);
      int n;
      to = 1'b1; g = '0; hold_ok = 1'b0; ack = '0; dout = '0; gap = 0;
      ack2 = '0; dout2 = '0; busy2 = 1'b0;
      cli_req = req;
      res_ack = 1'b0;
      n = 0;
      while (n < 50) begin
         @(posedge clk); #1;
         n++;
         if (res_req) begin
            to = 1'b0;
            break;
         end
      end
      if (to) return;
      g = grant;
      cli_req = req_fetch;
      hold_ok = busy & (cli_ack == '0);
      for (int k = 0; k < delay; k++) begin
         @(posedge clk); #1;
         hold_ok = hold_ok & res_req & busy & (cli_ack == '0);
      end
      res_ack = 1'b1;
      res_din = data;
      @(posedge clk); #1;
      res_ack = 1'b0;
      res_din = ~data;
      ack = cli_ack;
      dout = cli_dout;
      hold_ok = hold_ok & ~res_req;
      gap = cyc - last_ack_cyc;
      last_ack_cyc = cyc;
      @(posedge clk); #1;
      ack2 = cli_ack;
      dout2 = cli_dout;
      busy2 = busy;
   endtask

   typedef struct {
      logic          rst_before;
      logic [NC-1:0] req;
      int            delay;
      logic [DW-1:0] data;
      logic [2:0]    exp_grant;
      int            exp_gap;
   } vec_t;

   vec_t vecs[16];

   logic          to, hold_ok, busy2;
   logic [2:0]    g;
   logic [NC-1:0] ack, ack2;
   logic [DW-1:0] dout, dout2;
   int            gap;
   int            per_client[NC];

   initial begin
      vecs[0]  = '{1'b0, 4'b0001, 1,  32'h0,        3'd0, 0};
      vecs[1]  = '{1'b0, 4'b0001, 1,  32'h1,        3'd0, 4};
      vecs[2]  = '{1'b0, 4'b0001, 1,  32'h2,        3'd0, 4};
      vecs[3]  = '{1'b1, 4'b1111, 0,  32'h10,       3'd0, 0};
      vecs[4]  = '{1'b0, 4'b1111, 0,  32'h11,       3'd1, 3};
      vecs[5]  = '{1'b0, 4'b1111, 0,  32'h12,       3'd2, 3};
      vecs[6]  = '{1'b0, 4'b1111, 0,  32'h13,       3'd3, 3};
      vecs[7]  = '{1'b0, 4'b1111, 0,  32'h14,       3'd0, 3};
      vecs[8]  = '{1'b0, 4'b1111, 0,  32'h15,       3'd1, 3};
      vecs[9]  = '{1'b0, 4'b1111, 0,  32'h16,       3'd2, 3};
      vecs[10] = '{1'b0, 4'b1111, 0,  32'h17,       3'd3, 3};
      vecs[11] = '{1'b0, 4'b0110, 0,  32'h20,       3'd1, 3};
      vecs[12] = '{1'b0, 4'b0110, 0,  32'h21,       3'd2, 3};
      vecs[13] = '{1'b0, 4'b1001, 2,  32'h22,       3'd3, 5};
      vecs[14] = '{1'b0, 4'b1001, 0,  32'h23,       3'd0, 3};
      vecs[15] = '{1'b0, 4'b0100, 10, 32'hDEADBEEF, 3'd2, 13};

      for (int c = 0; c < NC; c++) per_client[c] = 0;
      res_din = '0;
      do_reset();

      check("reset_res_req", 64'(res_req), 64'd0);
      check("reset_cli_ack", 64'(cli_ack), 64'd0);
      check("reset_cli_dout", 64'(cli_dout), 64'd0);
      check("reset_grant", 64'(grant), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);

      // Idle with no requests: res_ack must not be captured.
      res_ack = 1'b1;
      res_din = 32'hCAFE;
      @(posedge clk); #1;
      res_ack = 1'b0;
      check("idle_res_req", 64'(res_req), 64'd0);
      check("idle_stray_dout", 64'(cli_dout), 64'd0);
      check("idle_stray_ack", 64'(cli_ack), 64'd0);

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].rst_before) do_reset();
         run_item(vecs[i].req, vecs[i].req, vecs[i].delay, vecs[i].data,
                  to, g, hold_ok, ack, dout, gap, ack2, dout2, busy2);
         check($sformatf("v%0d_timeout", i), 64'(to), 64'd0);
         check($sformatf("v%0d_grant", i), 64'(g), 64'(vecs[i].exp_grant));
         check($sformatf("v%0d_hold", i), 64'(hold_ok), 64'd1);
         check($sformatf("v%0d_ack", i), 64'(ack), 64'(4'b0001 << vecs[i].exp_grant));
         check($sformatf("v%0d_dout", i), 64'(dout), 64'(vecs[i].data));
         if (vecs[i].exp_gap != 0)
            check($sformatf("v%0d_gap", i), 64'(gap), 64'(vecs[i].exp_gap));
         check($sformatf("v%0d_ack_clear", i), 64'(ack2), 64'd0);
         check($sformatf("v%0d_dout_hold", i), 64'(dout2), 64'(vecs[i].data));
         check($sformatf("v%0d_busy_idle", i), 64'(busy2), 64'd0);
         if (i >= 3 && i <= 10)
            for (int c = 0; c < NC; c++) per_client[c] += int'(ack[c]);
      end
      for (int c = 0; c < NC; c++)
         check($sformatf("rr_count_c%0d", c), 64'(per_client[c]), 64'd2);

      // Client 2 withdraws during FETCH: still acked, next search starts at 3.
      do_reset();
      run_item(4'b0100, 4'b0000, 1, 32'h55, to, g, hold_ok, ack, dout, gap, ack2, dout2, busy2);
      check("wd_grant", 64'(g), 64'd2);
      check("wd_ack", 64'(ack), 64'b0100);
      check("wd_dout", 64'(dout), 64'h55);
      run_item(4'b1111, 4'b1111, 0, 32'h56, to, g, hold_ok, ack, dout, gap, ack2, dout2, busy2);
      check("wd_next_grant", 64'(g), 64'd3);
      check("wd_next_ack", 64'(ack), 64'b1000);

      // Reset in FETCH with a stray res_ack right after.
      do_reset();
      run_item(4'b0100, 4'b0100, 0, 32'h77, to, g, hold_ok, ack, dout, gap, ack2, dout2, busy2);
      check("rf_pre_grant", 64'(g), 64'd2);
      cli_req = 4'b0010;
      to = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (res_req) begin
            to = 1'b0;
            break;
         end
      end
      check("rf_fetch_timeout", 64'(to), 64'd0);
      check("rf_fetch_grant", 64'(grant), 64'd1);
      rst = 1'b1;
      cli_req = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      res_ack = 1'b1;
      res_din = 32'hBAD;
      check("rf_rst_res_req", 64'(res_req), 64'd0);
      check("rf_rst_busy", 64'(busy), 64'd0);
      check("rf_rst_grant", 64'(grant), 64'd0);
      @(posedge clk); #1;
      res_ack = 1'b0;
      check("rf_stray_ack", 64'(cli_ack), 64'd0);
      check("rf_stray_res_req", 64'(res_req), 64'd0);
      check("rf_stray_busy", 64'(busy), 64'd0);
      check("rf_stray_dout", 64'(cli_dout), 64'd0);
      @(posedge clk); #1;
      check("rf_idle_ack", 64'(cli_ack), 64'd0);
      run_item(4'b1111, 4'b1111, 0, 32'h88, to, g, hold_ok, ack, dout, gap, ack2, dout2, busy2);
      check("rf_next_grant", 64'(g), 64'd0);
      check("rf_next_ack", 64'(ack), 64'b0001);

`ifdef OP_SHARE_ARBITER_STATS_EN
      begin
         int total;
         logic [31:0] sum;
         do_reset();
         check("st_reset", 64'(gnt_count), 64'd0);
         total = 0;
         for (int i = 0; i < 5000; i++) begin
            run_item(4'b1111, 4'b1111, 0, 32'(i), to, g, hold_ok, ack, dout, gap, ack2, dout2, busy2);
            total += $countones(ack);
         end
         sum = '0;
         for (int c = 0; c < NC; c++) begin
            logic [32*NC-1:0] v;
            v = gnt_count >> (32 * c);
            check($sformatf("st_count_c%0d", c), 64'(v[31:0]), 64'd1250);
            sum = sum + v[31:0];
         end
         check("st_total", 64'(total), 64'd5000);
         check("st_sum", 64'(sum), 64'(total));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
